// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared direction codes, sequencer state encoding and duty width
package motor_pkg;

    localparam int DUTY_W = 8;

    localparam logic [1:0] DIR_STOP  = 2'b00;
    localparam logic [1:0] DIR_CW    = 2'b01;
    localparam logic [1:0] DIR_CCW   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DOWN = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

endpackage

// File: rtl/motor_ramp_sequencer_if.sv
// rtl/motor_ramp_sequencer_if.sv - request/command bundle between control logic, sequencer and bridge
//   dir_req, duty_req, estop : raw requests from control logic (master drives)
//   sel, pwm_duty            : conditioned command for the H-bridge controller (slave drives)
//   busy, at_target          : sequencer status (slave drives)
interface motor_ramp_sequencer_if;
    import motor_pkg::*;

    logic [1:0]        dir_req;
    logic [DUTY_W-1:0] duty_req;
    logic              estop;
    logic [1:0]        sel;
    logic [DUTY_W-1:0] pwm_duty;
    logic              busy;
    logic              at_target;

    modport master (
        output dir_req, duty_req, estop,
        input  sel, pwm_duty, busy, at_target
    );

    modport slave (
        input  dir_req, duty_req, estop,
        output sel, pwm_duty, busy, at_target
    );

endinterface

// File: rtl/motor_step_tick.sv
// rtl/motor_step_tick.sv - duty step prescaler with synchronous clear
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count at 0 on the next edge
//   tick       : high for one cycle on the terminal count STEP_CYCLES-1
module motor_step_tick #(
    parameter int STEP_CYCLES = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Not gated by clear: the sequencer decides state changes from this tick,
    // and clear is itself derived from those decisions.
    assign tick = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/motor_ramp_sequencer.sv
// rtl/motor_ramp_sequencer.sv - slew-limited direction/duty sequencer ahead of the H-bridge controller
//   clk, rst_n : 50 MHz clock, asynchronous active-low reset
//   bus        : slave side of motor_ramp_sequencer_if (requests in, sel/pwm_duty/busy/at_target out)
module motor_ramp_sequencer
    import motor_pkg::*;
#(
    parameter int STEP_CYCLES     = 50_000,
    parameter int DEADTIME_CYCLES = 5_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    motor_ramp_sequencer_if.slave  bus
);

    localparam int DEAD_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_CYCLES - 1);

    state_t            state, state_n;
    logic [1:0]        active_dir, active_dir_n;
    logic [1:0]        sel_q, sel_n;
    logic [DUTY_W-1:0] duty_q, duty_n;
    logic [DEAD_W-1:0] dead_cnt, dead_n;
    logic              busy_q, busy_n;
    logic              at_q, at_n;
    logic              abort, req_drive;
    logic              step_clear, step_tick;

    motor_step_tick #(.STEP_CYCLES(STEP_CYCLES)) u_step_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (step_clear),
        .tick  (step_tick)
    );

    assign abort     = bus.estop || (bus.dir_req == DIR_BRAKE);
    assign req_drive = (bus.dir_req == DIR_CW) || (bus.dir_req == DIR_CCW);

    always_comb begin
        state_n      = state;
        active_dir_n = active_dir;
        duty_n       = duty_q;
        dead_n       = dead_cnt;

        unique case (state)
            ST_IDLE: begin
                duty_n = '0;
                if (req_drive && (bus.duty_req != '0)) begin
                    state_n      = ST_RAMP;
                    active_dir_n = bus.dir_req;
                end
            end
            ST_RAMP: begin
                if ((bus.dir_req != active_dir) || (bus.duty_req == '0)) begin
                    state_n = ST_DOWN;
                end else if (step_tick) begin
                    if (duty_q < bus.duty_req) begin
                        duty_n = duty_q + 1'b1;
                    end else if (duty_q > bus.duty_req) begin
                        duty_n = duty_q - 1'b1;
                    end
                end
            end
            ST_DOWN: begin
                // Leave on the same edge that lands on zero so the dead time
                // starts without an extra cycle of sel held at zero duty.
                if (duty_q == '0) begin
                    state_n = ST_DEAD;
                    dead_n  = '0;
                end else if (step_tick) begin
                    duty_n = duty_q - 1'b1;
                    if (duty_q == DUTY_W'(1)) begin
                        state_n = ST_DEAD;
                        dead_n  = '0;
                    end
                end
            end
            ST_DEAD: begin
                duty_n = '0;
                if (dead_cnt == DEAD_LAST) begin
                    state_n = ST_IDLE;
                    dead_n  = '0;
                end else begin
                    dead_n = dead_cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Abort overrides everything and pins the dead counter until released.
        if (abort) begin
            state_n = ST_DEAD;
            duty_n  = '0;
            dead_n  = '0;
        end

        sel_n  = ((state_n == ST_RAMP) || (state_n == ST_DOWN)) ? active_dir_n : DIR_STOP;
        busy_n = (state_n != ST_IDLE);
        at_n   = (state_n == ST_RAMP) && (duty_n == bus.duty_req);

        // Restart the prescaler on every state change and keep it parked
        // outside the stepping states, so the first step is a full period away.
        step_clear = (state_n != state) || !((state_n == ST_RAMP) || (state_n == ST_DOWN));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            active_dir <= DIR_STOP;
            sel_q      <= DIR_STOP;
            duty_q     <= '0;
            dead_cnt   <= '0;
            busy_q     <= 1'b0;
            at_q       <= 1'b0;
        end else begin
            state      <= state_n;
            active_dir <= active_dir_n;
            sel_q      <= sel_n;
            duty_q     <= duty_n;
            dead_cnt   <= dead_n;
            busy_q     <= busy_n;
            at_q       <= at_n;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.pwm_duty  = duty_q;
    assign bus.busy      = busy_q;
    assign bus.at_target = at_q;

endmodule
